// File: rtl/mp3_frame_sync.sv
// mp3_frame_sync: MPEG-1 Layer III byte-stream sync hunter and header decoder.
// Validates 4-byte headers, sizes frames, forwards body bytes and tracks lock.
module mp3_frame_sync #(
   parameter int unsigned LOCK_FRAMES = 2,
   parameter logic [2:0]  FS_MASK     = 3'b111,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       axiid,
   input  logic             axiiv,
   output logic [7:0]       axiod,
   output logic             axiov,
   output logic             axiol,
   output logic             hdr_valid,
   output logic             prot,
   output logic [8:0]       bitrate,
   output logic [15:0]      samp_rate,
   output logic             padding,
   output logic             private,
   output logic [1:0]       mode,
   output logic [1:0]       mode_ext,
   output logic [1:0]       emphasis,
   output logic [10:0]      frame_size,
   output logic             sync_locked,
   output logic             sync_err,
   output logic [CNT_W-1:0] frame_count
);

   typedef enum logic [2:0] {
      HUNT, GOT_FF, HDR2, HDR3, BODY, EXPECT, EXP_FF
   } state_t;

   state_t state_q, state_d;
   logic [7:0]  b3_q, b3_d;
   logic        pprot_q, pprot_d;
   logic        lockp_q, lockp_d;
   logic [10:0] rem_q, rem_d;
   logic [3:0]  lock_q, lock_d;

   logic [7:0]       axiod_q, axiod_d;
   logic             axiov_q, axiov_d, axiol_q, axiol_d;
   logic             hv_q, hv_d, err_q, err_d;
   logic             prot_q, prot_d, pad_q, pad_d, priv_q, priv_d;
   logic [8:0]       br_q, br_d;
   logic [15:0]      sr_q, sr_d;
   logic [1:0]       mode_q, mode_d, mext_q, mext_d, emph_q, emph_d;
   logic [10:0]      fsz_q, fsz_d;
   logic             locked_q, locked_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic        hdr_acc, hdr_rej, lost, body_byte, body_last;
   logic        sync_b, hdr_ok;
   logic [3:0]  bi;
   logic [1:0]  fi;
   logic [3:0]  fs_en;
   logic [8:0]  br_w;
   logic [11:0] x9_w;
   logic [10:0] base_w, fsz_w;
   logic [15:0] sr_w;

   function automatic logic [8:0] br_of(input logic [3:0] i);
      unique case (i)
         4'd1: br_of = 9'd32;    4'd2: br_of = 9'd40;
         4'd3: br_of = 9'd48;    4'd4: br_of = 9'd56;
         4'd5: br_of = 9'd64;    4'd6: br_of = 9'd80;
         4'd7: br_of = 9'd96;    4'd8: br_of = 9'd112;
         4'd9: br_of = 9'd128;   4'd10: br_of = 9'd160;
         4'd11: br_of = 9'd192;  4'd12: br_of = 9'd224;
         4'd13: br_of = 9'd256;  4'd14: br_of = 9'd320;
         default: br_of = 9'd0;
      endcase
   endfunction

   // 44.1 kHz sizes are not integer multiples of the bitrate
   function automatic logic [10:0] rom44(input logic [3:0] i);
      unique case (i)
         4'd1: rom44 = 11'd104;   4'd2: rom44 = 11'd130;
         4'd3: rom44 = 11'd156;   4'd4: rom44 = 11'd182;
         4'd5: rom44 = 11'd208;   4'd6: rom44 = 11'd261;
         4'd7: rom44 = 11'd313;   4'd8: rom44 = 11'd365;
         4'd9: rom44 = 11'd417;   4'd10: rom44 = 11'd522;
         4'd11: rom44 = 11'd626;  4'd12: rom44 = 11'd731;
         4'd13: rom44 = 11'd835;  4'd14: rom44 = 11'd1044;
         default: rom44 = 11'd0;
      endcase
   endfunction

   assign bi     = b3_q[7:4];
   assign fi     = b3_q[3:2];
   assign fs_en  = {1'b0, FS_MASK};
   assign sync_b = (axiid[7:1] == 7'b1111101);
   assign br_w   = br_of(bi);
   assign x9_w   = 12'(br_w) * 12'd9;

   always_comb begin
      base_w = rom44(bi);
      sr_w   = 16'd44100;
      unique case (fi)
         2'd1: begin
            base_w = 11'(br_w) * 11'd3;
            sr_w   = 16'd48000;
         end
         2'd2: begin
            base_w = x9_w[11:1];
            sr_w   = 16'd32000;
         end
         default: ;
      endcase
   end

   assign fsz_w  = base_w + 11'(b3_q[1]);
   assign hdr_ok = (bi != 4'd0) && (bi != 4'hF) && fs_en[fi] &&
                   (axiid[1:0] != 2'b10);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= HUNT;
         b3_q     <= '0;
         pprot_q  <= 1'b0;
         lockp_q  <= 1'b0;
         rem_q    <= '0;
         lock_q   <= '0;
         axiod_q  <= '0;
         axiov_q  <= 1'b0;
         axiol_q  <= 1'b0;
         hv_q     <= 1'b0;
         err_q    <= 1'b0;
         prot_q   <= 1'b0;
         pad_q    <= 1'b0;
         priv_q   <= 1'b0;
         br_q     <= '0;
         sr_q     <= '0;
         mode_q   <= '0;
         mext_q   <= '0;
         emph_q   <= '0;
         fsz_q    <= '0;
         locked_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         b3_q     <= b3_d;
         pprot_q  <= pprot_d;
         lockp_q  <= lockp_d;
         rem_q    <= rem_d;
         lock_q   <= lock_d;
         axiod_q  <= axiod_d;
         axiov_q  <= axiov_d;
         axiol_q  <= axiol_d;
         hv_q     <= hv_d;
         err_q    <= err_d;
         prot_q   <= prot_d;
         pad_q    <= pad_d;
         priv_q   <= priv_d;
         br_q     <= br_d;
         sr_q     <= sr_d;
         mode_q   <= mode_d;
         mext_q   <= mext_d;
         emph_q   <= emph_d;
         fsz_q    <= fsz_d;
         locked_q <= locked_d;
         cnt_q    <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      b3_d      = b3_q;
      pprot_d   = pprot_q;
      lockp_d   = lockp_q;
      rem_d     = rem_q;
      hdr_acc   = 1'b0;
      hdr_rej   = 1'b0;
      lost      = 1'b0;
      body_byte = 1'b0;
      body_last = 1'b0;
      if (axiiv) begin
         unique case (state_q)
            HUNT: if (axiid == 8'hFF) state_d = GOT_FF;
            GOT_FF: begin
               if (sync_b) begin
                  state_d = HDR2;
                  pprot_d = axiid[0];
                  lockp_d = 1'b0;
               end else if (axiid != 8'hFF) begin
                  state_d = HUNT;
               end
            end
            HDR2: begin
               b3_d    = axiid;
               state_d = HDR3;
            end
            HDR3: begin
               if (hdr_ok) begin
                  hdr_acc = 1'b1;
                  rem_d   = fsz_w - 11'd4;
                  state_d = BODY;
               end else begin
                  hdr_rej = 1'b1;
                  state_d = HUNT;
               end
            end
            BODY: begin
               body_byte = 1'b1;
               rem_d     = rem_q - 11'd1;
               if (rem_q == 11'd1) begin
                  body_last = 1'b1;
                  state_d   = EXPECT;
               end
            end
            EXPECT: begin
               if (axiid == 8'hFF) begin
                  state_d = EXP_FF;
               end else begin
                  lost    = 1'b1;
                  state_d = HUNT;
               end
            end
            EXP_FF: begin
               if (sync_b) begin
                  state_d = HDR2;
                  pprot_d = axiid[0];
                  lockp_d = 1'b1;
               end else begin
                  lost    = 1'b1;
                  state_d = HUNT;
               end
            end
            default: state_d = HUNT;
         endcase
      end
   end

   always_comb begin
      axiod_d  = body_byte ? axiid : axiod_q;
      axiov_d  = body_byte;
      axiol_d  = body_last;
      hv_d     = hdr_acc;
      err_d    = hdr_rej | lost;
      prot_d   = prot_q;
      pad_d    = pad_q;
      priv_d   = priv_q;
      br_d     = br_q;
      sr_d     = sr_q;
      mode_d   = mode_q;
      mext_d   = mext_q;
      emph_d   = emph_q;
      fsz_d    = fsz_q;
      cnt_d    = cnt_q;
      lock_d   = lock_q;
      locked_d = locked_q;
      if (hdr_acc) begin
         prot_d = pprot_q;
         pad_d  = b3_q[1];
         priv_d = b3_q[0];
         br_d   = br_w;
         sr_d   = sr_w;
         mode_d = axiid[7:6];
         mext_d = axiid[5:4];
         emph_d = axiid[1:0];
         fsz_d  = fsz_w;
         cnt_d  = cnt_q + CNT_W'(1);
         // a header found by hunting restarts the lock run at one
         if (!lockp_q)
            lock_d = 4'd1;
         else if (lock_q != 4'hF)
            lock_d = lock_q + 4'd1;
         locked_d = (32'(lock_d) >= LOCK_FRAMES);
      end else if (hdr_rej || lost) begin
         lock_d   = '0;
         locked_d = 1'b0;
      end
   end

   assign axiod       = axiod_q;
   assign axiov       = axiov_q;
   assign axiol       = axiol_q;
   assign hdr_valid   = hv_q;
   assign sync_err    = err_q;
   assign prot        = prot_q;
   assign bitrate     = br_q;
   assign samp_rate   = sr_q;
   assign padding     = pad_q;
   assign private     = priv_q;
   assign mode        = mode_q;
   assign mode_ext    = mext_q;
   assign emphasis    = emph_q;
   assign frame_size  = fsz_q;
   assign sync_locked = locked_q;
   assign frame_count = cnt_q;

endmodule

// File: tb/tb_mp3_frame_sync.sv
// tb_mp3_frame_sync: directed and randomized frames for mp3_frame_sync,
// checked against a behavioural header/frame model.
module tb_mp3_frame_sync;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  axiid = '0;
   logic        axiiv = 1'b0;

   logic [7:0]  axiod;
   logic        axiov, axiol, hdr_valid, prot, padding, priv;
   logic [8:0]  bitrate;
   logic [15:0] samp_rate, frame_count;
   logic [1:0]  mode, mode_ext, emphasis;
   logic [10:0] frame_size;
   logic        sync_locked, sync_err;

   logic [7:0]  m_axiod;
   logic        m_axiov, m_axiol, m_hdr_valid, m_prot, m_padding, m_priv;
   logic [8:0]  m_bitrate;
   logic [15:0] m_samp_rate, m_frame_count;
   logic [1:0]  m_mode, m_mode_ext, m_emphasis;
   logic [10:0] m_frame_size;
   logic        m_sync_locked, m_sync_err;

   always #5 clk = ~clk;

   mp3_frame_sync u_dut (
      .clk(clk), .rst(rst), .axiid(axiid), .axiiv(axiiv),
      .axiod(axiod), .axiov(axiov), .axiol(axiol),
      .hdr_valid(hdr_valid), .prot(prot), .bitrate(bitrate),
      .samp_rate(samp_rate), .padding(padding), .private(priv),
      .mode(mode), .mode_ext(mode_ext), .emphasis(emphasis),
      .frame_size(frame_size), .sync_locked(sync_locked),
      .sync_err(sync_err), .frame_count(frame_count)
   );

   mp3_frame_sync #(.FS_MASK(3'b011)) u_msk (
      .clk(clk), .rst(rst), .axiid(axiid), .axiiv(axiiv),
      .axiod(m_axiod), .axiov(m_axiov), .axiol(m_axiol),
      .hdr_valid(m_hdr_valid), .prot(m_prot), .bitrate(m_bitrate),
      .samp_rate(m_samp_rate), .padding(m_padding), .private(m_priv),
      .mode(m_mode), .mode_ext(m_mode_ext), .emphasis(m_emphasis),
      .frame_size(m_frame_size), .sync_locked(m_sync_locked),
      .sync_err(m_sync_err), .frame_count(m_frame_count)
   );

   int n_assert = 0;
   int n_fail   = 0;
   logic [7:0] exp_q[$];
   logic [7:0] got_q[$];
   int ol_pos, nol, nhv, nerr, m_nhv, m_nerr;
   int novl = 0;
   bit gaps = 1'b0;
   int BR_T[16] = '{0, 32, 40, 48, 56, 64, 80, 96, 112, 128,
                    160, 192, 224, 256, 320, 0};

   always @(negedge clk) begin
      if (axiov) got_q.push_back(axiod);
      if (axiol) begin
         nol++;
         ol_pos = got_q.size();
      end
      if (hdr_valid) nhv++;
      if (sync_err) nerr++;
      if (m_hdr_valid) m_nhv++;
      if (m_sync_err) m_nerr++;
      if (hdr_valid && (axiov || sync_err)) novl++;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: observed timeout expected finish");
      $fatal(1, "watchdog");
   end

   function automatic int fs_hz(input logic [1:0] fi);
      case (fi)
         2'd0: return 44100;
         2'd1: return 48000;
         2'd2: return 32000;
         default: return 0;
      endcase
   endfunction

   function automatic int fsize(input logic [7:0] b3);
      return 144000 * BR_T[b3[7:4]] / fs_hz(b3[3:2]) + int'(b3[1]);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic clear_mon();
      got_q.delete();
      exp_q.delete();
      ol_pos = 0; nol = 0; nhv = 0; nerr = 0;
      m_nhv = 0; m_nerr = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      axiiv = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 clear_mon();
   endtask

   task automatic send(input logic [7:0] b);
      if (gaps && $urandom_range(0, 3) == 0)
         repeat ($urandom_range(1, 3)) begin
            @(posedge clk);
            #1;
         end
      axiid = b;
      axiiv = 1'b1;
      @(posedge clk);
      #1 axiiv = 1'b0;
   endtask

   task automatic send_hdr(input logic [31:0] h);
      send(h[31:24]);
      send(h[23:16]);
      send(h[15:8]);
      send(h[7:0]);
   endtask

   task automatic send_body(input int n, input bit inc);
      logic [7:0] b;
      for (int i = 0; i < n; i++) begin
         b = inc ? 8'(i) : 8'($urandom);
         exp_q.push_back(b);
         send(b);
      end
   endtask

   task automatic settle();
      repeat (3) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_body(input string tag);
      int bad = 0;
      check({tag, "_nbytes"}, got_q.size(), exp_q.size());
      for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
         if (got_q[i] !== exp_q[i]) bad++;
      check({tag, "_data"}, bad, 0);
      check({tag, "_ol_pos"}, ol_pos, exp_q.size());
      check({tag, "_nol"}, nol, 1);
   endtask

   task automatic check_fields(input string tag, input logic [31:0] h);
      logic [7:0] b2, b3, b4;
      b2 = h[23:16];
      b3 = h[15:8];
      b4 = h[7:0];
      check({tag, "_prot"}, prot, b2[0]);
      check({tag, "_bitrate"}, bitrate, BR_T[b3[7:4]]);
      check({tag, "_samp"}, samp_rate, fs_hz(b3[3:2]));
      check({tag, "_pad"}, padding, b3[1]);
      check({tag, "_priv"}, priv, b3[0]);
      check({tag, "_mode"}, mode, b4[7:6]);
      check({tag, "_mext"}, mode_ext, b4[5:4]);
      check({tag, "_emph"}, emphasis, b4[1:0]);
      check({tag, "_fsize"}, frame_size, fsize(b3));
   endtask

   function automatic logic [31:0] gen_hdr();
      logic [3:0] bi;
      logic [1:0] fi, em;
      bi = 4'($urandom_range(1, 14));
      fi = 2'($urandom_range(0, 2));
      em = 2'($urandom_range(0, 2));
      if (em == 2'd2) em = 2'd3;
      return {8'hFF, 7'b1111101, 1'($urandom), bi, fi, 2'($urandom),
              4'($urandom), 2'($urandom), em};
   endfunction

   function automatic logic any_out();
      return |{axiod, axiov, axiol, hdr_valid, prot, bitrate, samp_rate,
               padding, priv, mode, mode_ext, emphasis, frame_size,
               sync_locked, sync_err, frame_count};
   endfunction

   initial begin
      logic [31:0] h;
      int lock_m;
      do_reset();
      check("reset_outs", any_out(), 0);

      send_hdr(32'hFFFB9064);
      check("t1_hv_timing", hdr_valid, 1);
      check("t1_no_ov_at_hv", axiov, 0);
      send_body(413, 1);
      settle();
      check_fields("t1", 32'hFFFB9064);
      check("t1_br_lit", bitrate, 128);
      check("t1_fsize_lit", frame_size, 417);
      check("t1_count", frame_count, 1);
      check("t1_locked", sync_locked, 0);
      check("t1_nhv", nhv, 1);
      check_body("t1");
      clear_mon();

      send_hdr(32'hFFFB9064);
      check("t2_hv", hdr_valid, 1);
      check("t2_locked", sync_locked, 1);
      send_body(413, 1);
      settle();
      check_body("t2");
      check("t2_count", frame_count, 2);
      clear_mon();
      send(8'h12);
      check("t2_err", sync_err, 1);
      check("t2_unlock", sync_locked, 0);
      @(posedge clk);
      #1 check("t2_err_pulse", sync_err, 0);
      check("t2_nerr", nerr, 1);
      clear_mon();

      send(8'h00);
      send(8'hFF);
      send_hdr(32'hFFFB9400);
      send_body(380, 0);
      settle();
      check_fields("t3", 32'hFFFB9400);
      check("t3_samp_lit", samp_rate, 48000);
      check("t3_fsize_lit", frame_size, 384);
      check_body("t3");
      check("t3_count", frame_count, 3);
      check("t3_locked", sync_locked, 0);
      check("t3_nerr", nerr, 0);
      clear_mon();

      send_hdr(32'hFFFBF000);
      settle();
      check("t4_nerr", nerr, 1);
      check("t4_nhv", nhv, 0);
      check("t4_nov", got_q.size(), 0);
      check("t4_count", frame_count, 3);
      check("t4_locked", sync_locked, 0);

      do_reset();
      send_hdr(32'hFFFB9800);
      settle();
      check("t5_msk_err", m_nerr, 1);
      check("t5_msk_nhv", m_nhv, 0);
      check("t5_full_nhv", nhv, 1);
      check("t5_full_fsize", frame_size, 576);
      do_reset();
      send_hdr(32'hFFFB9A00);
      send_body(573, 0);
      settle();
      check_fields("t5", 32'hFFFB9A00);
      check("t5_fsize_lit", frame_size, 577);
      check_body("t5");

      do_reset();
      gaps = 1'b1;
      send_hdr(32'hFFFB9064);
      send_body(100, 0);
      rst = 1'b1;
      #1 check("t6_rst_outs", any_out(), 0);
      check("t6_rst_nol", nol, 0);
      @(posedge clk);
      #1 rst = 1'b0;
      clear_mon();
      h = gen_hdr();
      send_hdr(h);
      send_body(fsize(h[15:8]) - 4, 0);
      settle();
      check_fields("t6", h);
      check_body("t6");
      check("t6_count", frame_count, 1);
      lock_m = 1;
      check("t6_locked", sync_locked, lock_m >= 2);
      clear_mon();

      for (int k = 0; k < 5; k++) begin
         h = gen_hdr();
         send_hdr(h);
         send_body(fsize(h[15:8]) - 4, 0);
         settle();
         lock_m = (lock_m < 15) ? lock_m + 1 : 15;
         check_fields($sformatf("r%0d", k), h);
         check_body($sformatf("r%0d", k));
         check($sformatf("r%0d_count", k), frame_count, k + 2);
         check($sformatf("r%0d_locked", k), sync_locked, lock_m >= 2);
         check($sformatf("r%0d_nerr", k), nerr, 0);
         clear_mon();
      end

      check("no_overlap", novl, 0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
